// File: rtl/dmem_slave_pkg.sv
//------------------------------------------------------------------------------
// Module  : dmem_slave_pkg
// Brief   : Store-size / load-type opcodes and FSM states for dmem_slave.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package dmem_slave_pkg;

    localparam logic [1:0] SC_SW  = 2'b01;
    localparam logic [1:0] SC_SH  = 2'b10;
    localparam logic [1:0] SC_SB  = 2'b11;

    localparam logic [2:0] LC_LW  = 3'b001;
    localparam logic [2:0] LC_LH  = 3'b010;
    localparam logic [2:0] LC_LHU = 3'b011;
    localparam logic [2:0] LC_LB  = 3'b100;
    localparam logic [2:0] LC_LBU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_slave_if.sv
//------------------------------------------------------------------------------
// Module  : dmem_slave_if
// Brief   : MEM-stage request/response bus; err exists only with DMEM_MISALIGN_CHK_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface dmem_slave_if;
    logic        CS;
    logic        DM_W;
    logic        DM_R;
    logic [1:0]  SC;
    logic [2:0]  LC;
    logic [31:0] DMEMaddr;
    logic [31:0] Data_in;
    logic [31:0] Data_out;
    logic        ready;
    logic        busy;
`ifdef DMEM_MISALIGN_CHK_EN
    logic        err;

    modport master (output CS, DM_W, DM_R, SC, LC, DMEMaddr, Data_in,
                    input  Data_out, ready, busy, err);
    modport slave  (input  CS, DM_W, DM_R, SC, LC, DMEMaddr, Data_in,
                    output Data_out, ready, busy, err);
`else
    modport master (output CS, DM_W, DM_R, SC, LC, DMEMaddr, Data_in,
                    input  Data_out, ready, busy);
    modport slave  (input  CS, DM_W, DM_R, SC, LC, DMEMaddr, Data_in,
                    output Data_out, ready, busy);
`endif
endinterface

`default_nettype wire

// File: rtl/dmem_lane_ext.sv
//------------------------------------------------------------------------------
// Module  : dmem_lane_ext
// Brief   : Lane select, byte enables, store replication, load extension, alignment check.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_lane_ext
    import dmem_slave_pkg::*;
(
    input  logic        is_store_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  sc_i,
    input  logic [2:0]  lc_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        be_o    = 4'b1111;
        wword_o = wdata_i;
        case (sc_i)
            SC_SB: begin
                be_o    = 4'b0001 << lane_i;
                wword_o = {4{wdata_i[7:0]}};
            end
            SC_SH: begin
                be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
                wword_o = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (lane_i)
            2'd0:    w_byte = rword_i[7:0];
            2'd1:    w_byte = rword_i[15:8];
            2'd2:    w_byte = rword_i[23:16];
            default: w_byte = rword_i[31:24];
        endcase
        w_half = lane_i[1] ? rword_i[31:16] : rword_i[15:0];
        case (lc_i)
            LC_LH:   rdata_o = {{16{w_half[15]}}, w_half};
            LC_LHU:  rdata_o = {16'h0000, w_half};
            LC_LB:   rdata_o = {{24{w_byte[7]}}, w_byte};
            LC_LBU:  rdata_o = {24'h000000, w_byte};
            default: rdata_o = rword_i;
        endcase
    end

    always_comb begin
        misalign_o = 1'b0;
        if (is_store_i) begin
            case (sc_i)
                SC_SB:   misalign_o = 1'b0;
                SC_SH:   misalign_o = lane_i[0];
                default: misalign_o = (lane_i != 2'd0);
            endcase
        end else begin
            case (lc_i)
                LC_LB, LC_LBU: misalign_o = 1'b0;
                LC_LH, LC_LHU: misalign_o = lane_i[0];
                default:       misalign_o = (lane_i != 2'd0);
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_slave.sv
//------------------------------------------------------------------------------
// Module  : dmem_slave
// Brief   : Wait-stated data-memory responder; DMEM_MISALIGN_CHK_EN adds the err flag.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_slave
    import dmem_slave_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    dmem_slave_if.slave  bus
);

    localparam logic [3:0] C_WAIT  = 4'(WAIT_CYCLES);
    localparam int         C_DEPTH = 1 << ADDR_W;

    dmem_state_e        state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               w_accept;
    logic               w_commit;

    logic [ADDR_W-1:0]  idx_q;
    logic [1:0]         lane_q;
    logic [1:0]         sc_q;
    logic [2:0]         lc_q;
    logic [31:0]        data_q;
    logic               wr_q;
    logic [31:0]        dout_q;

    logic               w_live;
    logic [ADDR_W-1:0]  w_idx;
    logic [1:0]         w_lane;
    logic [1:0]         w_sc;
    logic [2:0]         w_lc;
    logic [31:0]        w_data;
    logic               w_wr;

    logic [31:0]        w_rword;
    logic [3:0]         w_be;
    logic [31:0]        w_wword;
    logic [31:0]        w_rdata;
    logic               w_misalign;
    logic [31:0]        w_merged;
    logic               w_unused;

    logic [31:0]        mem [C_DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        w_accept = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.CS && (bus.DM_W ^ bus.DM_R)) begin
                    w_accept = 1'b1;
                    cnt_d    = 4'd0;
                    state_d  = (C_WAIT == 4'd0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == C_WAIT) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.ready = (state_q == ST_RESP);
        bus.busy  = (state_q != ST_IDLE);
    end

    assign bus.Data_out = dout_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q  <= '0;
            lane_q <= 2'd0;
            sc_q   <= 2'd0;
            lc_q   <= 3'd0;
            data_q <= 32'd0;
            wr_q   <= 1'b0;
        end else if (w_accept) begin
            idx_q  <= bus.DMEMaddr[ADDR_W+1:2];
            lane_q <= bus.DMEMaddr[1:0];
            sc_q   <= bus.SC;
            lc_q   <= bus.LC;
            data_q <= bus.Data_in;
            wr_q   <= bus.DM_W;
        end
    end

    // With zero wait states the commit edge is also the accept edge, so operands come straight off the bus.
    assign w_live = (state_q == ST_IDLE);
    assign w_idx  = w_live ? bus.DMEMaddr[ADDR_W+1:2] : idx_q;
    assign w_lane = w_live ? bus.DMEMaddr[1:0]        : lane_q;
    assign w_sc   = w_live ? bus.SC                   : sc_q;
    assign w_lc   = w_live ? bus.LC                   : lc_q;
    assign w_data = w_live ? bus.Data_in              : data_q;
    assign w_wr   = w_live ? bus.DM_W                 : wr_q;

    assign w_commit = (state_d == ST_RESP);
    assign w_rword  = mem[w_idx];
    assign w_merged = (w_rword & ~be_to_mask(w_be)) | (w_wword & be_to_mask(w_be));
    assign w_unused = ^{bus.DMEMaddr[31:ADDR_W+2], w_misalign};

    dmem_lane_ext u_lane_ext (
        .is_store_i (w_wr),
        .lane_i     (w_lane),
        .sc_i       (w_sc),
        .lc_i       (w_lc),
        .wdata_i    (w_data),
        .rword_i    (w_rword),
        .be_o       (w_be),
        .wword_o    (w_wword),
        .rdata_o    (w_rdata),
        .misalign_o (w_misalign)
    );

`ifdef DMEM_MISALIGN_CHK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (w_commit && w_wr && !w_misalign) begin
            mem[w_idx] <= w_merged;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q <= 32'd0;
            err_q  <= 1'b0;
        end else begin
            err_q <= w_commit & w_misalign;
            if (w_commit && (w_misalign || !w_wr)) begin
                dout_q <= w_misalign ? 32'd0 : w_rdata;
            end
        end
    end

    assign bus.err = err_q;
`else
    always_ff @(posedge clk) begin
        if (w_commit && w_wr) begin
            mem[w_idx] <= w_merged;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q <= 32'd0;
        end else if (w_commit && !w_wr) begin
            dout_q <= w_rdata;
        end
    end
`endif

endmodule

`default_nettype wire
